// File: rtl/alu_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Purpose: Shared opcode constants and scheduler state encoding for the
//          round-robin ALU scheduler.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module : alu_rr_sched_if
// Purpose: Request/response bus between NREQ clients and the shared ALU
//          scheduler.
// Ports  : (interface signals)
//   req_valid/req_ready  per-requester handshake, NREQ bits
//   req_a/req_b/req_op   2-bit fields packed per requester
//   rsp_valid/rsp_ready  response handshake
//   rsp_y, rsp_id        3-bit result and owning requester index
//   busy                 scheduler not idle
//   master modport: client side; slave modport: scheduler side
// Rev    : 1.0  initial release
// ============================================================================
interface alu_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_a;
    logic [2*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_y;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_sched_alu.sv
`default_nettype none
// ============================================================================
// Module : ALU_2bit
// Purpose: 2-bit ALU with a 3-bit result (add/sub/and/or).
// Ports  :
//   a_i, b_i  in  2  operands
//   op_i      in  2  opcode
//   y_o       out 3  result; add carry in bit 2, sub wraps mod 8
// Rev    : 1.0  initial release
// ============================================================================
module ALU_2bit
    import alu_pkg::*;
(
    input  wire logic [1:0] a_i,
    input  wire logic [1:0] b_i,
    input  wire logic [1:0] op_i,
    output logic      [2:0] y_o
);
    logic [2:0] w_a;
    logic [2:0] w_b;

    assign w_a = {1'b0, a_i};
    assign w_b = {1'b0, b_i};

    always_comb begin
        y_o = 3'b000;
        case (op_i)
            OP_ADD:  y_o = w_a + w_b;
            OP_SUB:  y_o = w_a - w_b;
            OP_AND:  y_o = w_a & w_b;
            default: y_o = w_a | w_b;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_rr_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Purpose: Combinational round-robin picker. Searches ptr+1, ptr+2, ...
//          modulo NREQ and returns the first valid requester.
// Ports  :
//   valid_i  in  NREQ  request vector
//   ptr_i    in  IDW   last granted index
//   grant_o  out NREQ  one-hot grant (zero when nothing valid)
//   idx_o    out IDW   winner index
//   any_o    out 1     at least one requester valid
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic [NREQ-1:0] valid_i,
    input  wire logic [IDW-1:0]  ptr_i,
    output logic      [NREQ-1:0] grant_o,
    output logic      [IDW-1:0]  idx_o,
    output logic                 any_o
);
    logic [IDW-1:0] w_cand;

    // Scan from the farthest candidate to the nearest so the nearest valid
    // one after ptr overwrites the others and ends up as the winner.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        w_cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IDW'((int'(ptr_i) + k) % NREQ);
            if (valid_i[w_cand]) begin
                any_o           = 1'b1;
                idx_o           = w_cand;
                grant_o         = '0;
                grant_o[w_cand] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module : alu_rr_sched
// Purpose: Round-robin scheduler sharing one ALU_2bit between NREQ
//          requesters. One op in flight; result returned on a common
//          response bus tagged with the requester id.
// Ports  :
//   clk  in  1  clock, rising edge
//   rst  in  1  asynchronous active-high reset
//   bus  slave modport of alu_rr_sched_if (requests, response, busy)
// Rev    : 1.0  initial release
// ============================================================================
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_rr_sched_if.slave bus
);
    state_e         state_q, state_d;
    // ptr doubles as the captured requester id: it is set to the winner
    // on every accept and not touched again until the next accept.
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [1:0]     a_q, a_d;
    logic [1:0]     b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [2:0]     rsp_y_q, rsp_y_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_win;
    logic            w_any;
    logic [2:0]      w_alu_y;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_win),
        .any_o   (w_any)
    );

    ALU_2bit u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (w_alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    a_d     = bus.req_a [{w_win, 1'b0} +: 2];
                    b_d     = bus.req_b [{w_win, 1'b0} +: 2];
                    op_d    = bus.req_op[{w_win, 1'b0} +: 2];
                    ptr_d   = w_win;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_y_d     = w_alu_y;
                rsp_id_d    = ptr_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant is only offered while idle; the handshake completes combinationally.
    assign bus.req_ready = (state_q == S_IDLE) ? w_grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire
